// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction geometry, opcodes and the fetch FSM encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned OP_W    = 2;

  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_LDI  = 2'b01;
  localparam logic [OP_W-1:0] OP_STOP = 2'b11;

  localparam logic [OP_W-1:0] STOP_OP = OP_STOP;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/prog_ram.sv
// Program memory: DEPTH x INSTR_W, one synchronous write port, one asynchronous read port.
module prog_ram #(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned IDX_W   = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: writable program memory, program counter and STOP-halting fetch FSM.
module instr_fetch_unit #(
  parameter int unsigned      INSTR_W = cpu_pkg::INSTR_W,
  parameter int unsigned      DEPTH   = 32,
  parameter int unsigned      ADDR_W  = 5,
  parameter int unsigned      OP_W    = cpu_pkg::OP_W,
  parameter logic [OP_W-1:0]  STOP_OP = cpu_pkg::STOP_OP
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               prog_err
);

  import cpu_pkg::*;

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               err_q, err_d;

  logic               ram_we;
  logic [INSTR_W-1:0] rd_word;
  logic               wr_in_range;
  logic               jump_in_range;
  logic               rd_is_stop;
  logic [ADDR_W-1:0]  pc_inc;

  prog_ram #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W)
  ) u_prog_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (prog_addr[IDX_W-1:0]),
    .wdata (prog_data),
    .raddr (pc_q[IDX_W-1:0]),
    .rdata (rd_word)
  );

  assign wr_in_range   = 32'(prog_addr) < DEPTH;
  assign jump_in_range = 32'(jump_addr) < DEPTH;
  assign rd_is_stop    = rd_word[INSTR_W-1 -: OP_W] == STOP_OP;
  assign pc_inc        = (pc_q == LAST_ADDR) ? '0 : pc_q + 1'b1;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (!jump_en && !stall && rd_is_stop) state_d = HALT;
      HALT:    if (start) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // The STOP word is presented with valid=1 on entry to HALT; halted rises one edge later.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    err_d    = err_q;
    ram_we   = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        ram_we = prog_we && wr_in_range;
        if (prog_we && !wr_in_range) err_d = 1'b1;
        valid_d = 1'b0;
        if (start) begin
          pc_d     = '0;
          halted_d = 1'b0;
        end else if (state_q == HALT) begin
          halted_d = 1'b1;
        end
      end
      FETCH: begin
        if (prog_we) err_d = 1'b1;
        if (jump_en) begin
          valid_d = 1'b0;
          if (jump_in_range) begin
            pc_d = jump_addr;
          end else begin
            pc_d  = '0;
            err_d = 1'b1;
          end
        end else if (!stall) begin
          instr_d = rd_word;
          valid_d = 1'b1;
          if (!rd_is_stop) pc_d = pc_inc;
        end
      end
      default: ;
    endcase
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign prog_err    = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (DEPTH=32, ADDR_W=6 so out-of-range addresses are expressible).
module tb_instr_fetch_unit;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          clear;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          start;
  logic          stall;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic [7:0]    instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          halted;
  logic          prog_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] fib [9] = '{8'h48, 8'h27, 8'h39, 8'h2C, 8'h07, 8'h32, 8'h2D, 8'h18, 8'hC3};

  instr_fetch_unit #(
    .INSTR_W (8),
    .DEPTH   (32),
    .ADDR_W  (AW),
    .OP_W    (2),
    .STOP_OP (2'b11)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted),
    .prog_err    (prog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fib();
    for (int i = 0; i < 9; i++) begin
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_data = fib[i];
      step();
    end
    prog_we = 1'b0;
  endtask

  task automatic restart();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_valid", 32'(instr_valid), 32'd0);
    chk("start_pc", 32'(pc), 32'd0);
    chk("start_halted", 32'(halted), 32'd0);
  endtask

  // Fetched word k is on instr after the step; pc holds on the STOP word.
  task automatic expect_seq(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      step();
      chk($sformatf("instr[%0d]", k), 32'(instr), 32'(fib[k]));
      chk($sformatf("valid[%0d]", k), 32'(instr_valid), 32'd1);
      chk($sformatf("pc[%0d]", k), 32'(pc), (fib[k][7:6] == 2'b11) ? 32'(k) : 32'(k + 1));
    end
  endtask

  task automatic expect_halt();
    step();
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd8);
    chk("halt_instr", 32'(instr), 32'hC3);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    #2;
    chk("clr_instr", 32'(instr), 32'd0);
    chk("clr_valid", 32'(instr_valid), 32'd0);
    chk("clr_pc", 32'(pc), 32'd0);
    chk("clr_halted", 32'(halted), 32'd0);
    chk("clr_err", 32'(prog_err), 32'd0);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_addr = '0;
    #1;
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(prog_err), 32'd0);
    #11;
    clear = 1'b0;
    step();

    // Straight run to STOP, then jump/stall ignored in HALT
    load_fib();
    restart();
    expect_seq(0, 8);
    expect_halt();
    jump_en = 1'b1; jump_addr = AW'(3); stall = 1'b1;
    step();
    jump_en = 1'b0; stall = 1'b0;
    chk("halt_jump_pc", 32'(pc), 32'd8);
    chk("halt_jump_valid", 32'(instr_valid), 32'd0);

    // Stall on 39 for three cycles
    restart();
    expect_seq(0, 2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", 32'(instr), 32'h39);
      chk("stall_pc", 32'(pc), 32'd3);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    expect_seq(3, 8);
    expect_halt();

    // Jump to 6 while 27 is presented, with stall also high
    restart();
    expect_seq(0, 1);
    jump_en = 1'b1; jump_addr = AW'(6); stall = 1'b1;
    step();
    jump_en = 1'b0; stall = 1'b0;
    chk("jmp_valid", 32'(instr_valid), 32'd0);
    chk("jmp_pc", 32'(pc), 32'd6);
    chk("jmp_err", 32'(prog_err), 32'd0);
    expect_seq(6, 8);
    expect_halt();

    // Out-of-range jump
    restart();
    expect_seq(0, 1);
    jump_en = 1'b1; jump_addr = AW'(40);
    step();
    jump_en = 1'b0;
    chk("badjmp_pc", 32'(pc), 32'd0);
    chk("badjmp_valid", 32'(instr_valid), 32'd0);
    chk("badjmp_err", 32'(prog_err), 32'd1);
    expect_seq(0, 8);
    expect_halt();
    chk("err_sticky", 32'(prog_err), 32'd1);

    // Write during FETCH is dropped and flagged; clear mid-fetch keeps program
    pulse_clear();
    restart();
    expect_seq(0, 1);
    prog_we = 1'b1; prog_addr = AW'(3); prog_data = 8'hFF;
    expect_seq(2, 2);
    prog_we = 1'b0;
    chk("fetchwr_err", 32'(prog_err), 32'd1);
    expect_seq(3, 4);
    pulse_clear();
    step();
    chk("idle_pc", 32'(pc), 32'd0);
    chk("idle_valid", 32'(instr_valid), 32'd0);
    restart();
    expect_seq(0, 8);
    expect_halt();

    // Out-of-range write in HALT must not alias onto word 8
    prog_we = 1'b1; prog_addr = AW'(40); prog_data = 8'h00;
    step();
    prog_we = 1'b0;
    chk("badwr_err", 32'(prog_err), 32'd1);
    restart();
    expect_seq(0, 8);
    expect_halt();

    // Simultaneous write to 0 and start: first fetch sees new data
    pulse_clear();
    prog_we = 1'b1; prog_addr = AW'(0); prog_data = 8'h55; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    step();
    chk("wf_instr", 32'(instr), 32'h55);
    chk("wf_valid", 32'(instr_valid), 32'd1);
    chk("wf_pc", 32'(pc), 32'd1);
    chk("wf_err", 32'(prog_err), 32'd0);

    // No STOP anywhere: pc wraps 31 -> 0 and fetch keeps going
    pulse_clear();
    for (int i = 0; i < 32; i++) begin
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = 8'h00;
      step();
    end
    prog_we = 1'b0;
    restart();
    for (int k = 0; k < 34; k++) begin
      step();
      chk("wrap_pc", 32'(pc), 32'((k + 1) % 32));
      chk("wrap_valid", 32'(instr_valid), 32'd1);
    end
    chk("wrap_instr", 32'(instr), 32'h00);
    chk("wrap_halted", 32'(halted), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Parametrised successor to the hard-wired instruction ROM. Holds a writable program memory, owns the program counter and streams instructions to the datapath. Detects the STOP opcode and halts by itself. Sits between the program loader/testbench and the CPU decode stage.

Parameters:
INSTR_W, 8, instruction width in bits
DEPTH, 32, program memory words
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH
OP_W, 2, opcode field width (instr[INSTR_W-1 -: OP_W])
STOP_OP, 2'b11, opcode that halts fetch

Ports:
clk  in  1  system clock
clear  in  1  asynchronous active-high reset
prog_we  in  1  program-memory write strobe
prog_addr  in  ADDR_W  write address
prog_data  in  INSTR_W  write data
start  in  1  one-cycle pulse: begin fetch at address 0
stall  in  1  hold current instruction and pc
jump_en  in  1  redirect pc
jump_addr  in  ADDR_W  jump target
instr  out  INSTR_W  current instruction
instr_valid  out  1  instr is meaningful this cycle
pc  out  ADDR_W  address of the next word to fetch
halted  out  1  STOP has been fetched
prog_err  out  1  sticky: rejected write or bad jump

Behaviour:
- One clock, clk. clear is asynchronous, active-high.
- clear forces: state=IDLE, pc=0, instr=0, instr_valid=0, halted=0, prog_err=0. Memory contents are not cleared.
- States: IDLE, FETCH, HALT.
- IDLE:
  - prog_we writes mem[prog_addr] <= prog_data on the edge.
  - start moves to FETCH with pc=0.
- FETCH, each edge without stall or jump:
  - instr <= mem[pc], instr_valid <= 1, pc <= pc+1.
  - pc wraps from DEPTH-1 to 0.
- Latency: start at edge T; mem[0] is on instr with instr_valid=1 after edge T+1.
- STOP detection: when the word fetched has opcode == STOP_OP:
  - instr is presented with instr_valid=1 for that cycle.
  - pc holds at the STOP address; next state HALT.
  - halted=1 from the following edge.
- HALT:
  - instr_valid=0; instr holds the STOP word.
  - Writes are allowed.
  - start restarts at pc=0 with halted cleared.
- stall=1 in FETCH: instr, instr_valid and pc all hold.
- jump_en=1 in FETCH:
  - Has priority over stall.
  - pc <= jump_addr and instr_valid <= 0 (one bubble); the fetch from the target follows on the next edge.
  - jump_addr >= DEPTH: pc <= 0 and prog_err <= 1.
- jump_en outside FETCH is ignored.
- prog_we while in FETCH: the write is dropped and prog_err <= 1.
- prog_we with prog_addr >= DEPTH: dropped, prog_err <= 1.
- Simultaneous start and prog_we in IDLE: the write completes and the fetch starts. The first fetch at pc=0 sees the new data if prog_addr==0 (write-first).
- start in FETCH is ignored. stall in IDLE/HALT has no effect.
- Reading an unwritten word returns X in simulation; the bench always loads before start.
- clear mid-fetch returns to IDLE immediately; the program is retained.
- prog_err clears only on clear.

Decomposition:
- Shared package cpu_pkg:
  - INSTR_W, OP_W, STOP_OP
  - state encoding (IDLE=2'd0, FETCH=2'd1, HALT=2'd2)
  - opcode constants (ADD=2'b00, LDI=2'b01, STOP=2'b11)
- One natural sub-module: prog_ram. It is a single-port-write, async-read DEPTH x INSTR_W array. The FSM, pc and output register live in the top.

Test Plan:
- Load Fibonacci program 48,27,39,2C,07,32,2D,18,C3 at 0..8, pulse start -> instr sequence 48,27,39,2C,07,32,2D,18,C3 on consecutive cycles with valid=1; halted=1 the cycle after C3; pc stays 8; instr_valid=0 thereafter.
- Same program, stall high for 3 cycles while instr=39 -> instr=39 and pc=3 held 3 extra cycles, then 2C follows.
- jump_en with jump_addr=6 while instr=27 -> one cycle valid=0, then 2D, 18, C3, halt.
- jump_addr=40 (DEPTH=32) -> pc=0, prog_err=1, fetch resumes at 48.
- prog_we during FETCH to addr 3 -> mem[3] unchanged (2C still fetched), prog_err=1; clear -> all outputs 0 and state IDLE; restart reproduces the sequence.
- Fill all 32 words with 00 (no STOP), start -> pc wraps 31 -> 0 and fetch continues without halting.
